pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, 128, payload width in bits (instr, imm, rs/rt data, alu result, etc. packed by the instantiating stage).
REQ-002 Parameter EXC_PC, 32'h0000_4180, PC value presented on out_pc after an exception request.
REQ-003 Port clk  input  1  clock. All state updates on the rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port flush  input  1  synchronous bubble insert (stage clear).
REQ-006 Port req  input  1  synchronous exception request (flush plus handler PC load).
REQ-007 Port in_valid  input  1  upstream entry valid.
REQ-008 Port in_ready  output  1  stage can accept an entry this cycle.
REQ-009 Port in_pc  input  32  upstream PC.
REQ-010 Port in_bd  input  1  upstream branch-delay-slot flag.
REQ-011 Port in_exc  input  5  upstream exception code.
REQ-012 Port in_data  input  DATA_W  upstream payload.
REQ-013 Port out_valid  output  1  held entry valid.
REQ-014 Port out_ready  input  1  downstream accepts the held entry.
REQ-015 Port out_pc / out_bd / out_exc / out_data  output  32/1/5/DATA_W  held entry fields.
REQ-016 Port stall_cnt  output  16  downstream stall count (present only with PIPE_STALL_CNT_EN).

Function
REQ-017 The stage SHALL be a 2-entry skid register (main + skid) with states EMPTY, FULL, SKID; outputs are always driven from main.
REQ-018 out_valid SHALL be 1 in FULL and SKID, 0 in EMPTY; in_ready SHALL be 0 in SKID, 1 otherwise, and is a registered output with no combinational path from out_ready.
REQ-019 Accept = in_valid & in_ready; drain = out_valid & out_ready.
REQ-020 EMPTY: accept -> FULL, main <= input; else stay EMPTY.
REQ-021 FULL: accept & drain -> FULL, main <= input; drain only -> EMPTY; accept only -> SKID, skid <= input; neither -> hold.
REQ-022 SKID: drain -> FULL, main <= skid; else hold. Input is never accepted in SKID.
REQ-023 All fields (pc, bd, exc, data) SHALL move as one entry; out_bd SHALL be the captured in_bd, never the previous out_bd.
REQ-024 Latency: an accepted entry SHALL appear on outputs the next cycle when the stage was EMPTY or draining.
REQ-025 Entries SHALL leave in acceptance order; no entry dropped or duplicated except by reset/flush/req.
REQ-026 flush SHALL, next cycle, set state EMPTY and zero main, skid, out_pc, out_bd, out_exc, out_data; an input offered in the flush cycle SHALL be discarded.
REQ-027 req SHALL act as flush except out_pc <= EXC_PC.
REQ-028 Priority reset > req > flush > normal operation; flush and req take effect regardless of out_ready.
REQ-029 Invalid-state outputs: in EMPTY, out_data/out_bd/out_exc SHALL remain at their last flushed or drained values; downstream SHALL qualify them with out_valid.

Reset
REQ-030 reset SHALL set state EMPTY, in_ready=1, out_valid=0, and zero out_pc, out_bd, out_exc, out_data and skid contents (out_pc=0, not EXC_PC).
REQ-031 reset asserted mid-operation (FULL or SKID) SHALL discard both entries in the same edge.

Configuration
REQ-032 With PIPE_STALL_CNT_EN defined, stall_cnt SHALL increment every cycle with out_valid=1 and out_ready=0, saturate at 16'hFFFF, clear only on reset (not flush/req).
REQ-033 Without PIPE_STALL_CNT_EN, the stall_cnt port and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-034 Reset, then in_valid=1, in_pc=32'h3000, in_bd=1, out_ready=1 -> next cycle out_valid=1, out_pc=32'h3000, out_bd=1.
REQ-035 FULL with pc 32'h3000, out_ready=0, push pc 32'h3004 -> SKID, in_ready=0; out_ready=1 -> out_pc 32'h3000 then 32'h3004, in order.
REQ-036 SKID state, req=1 -> next cycle out_valid=0, out_pc=32'h0000_4180, out_exc=0, in_ready=1; both entries lost.
REQ-037 FULL, flush=1 with in_valid=1 pc 32'h3008 -> next cycle EMPTY, out_pc=0, 32'h3008 never appears.
REQ-038 flush=1, req=1 together -> out_pc=32'h0000_4180; reset=1 with req=1 -> out_pc=0.
REQ-039 PIPE_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF; flush -> unchanged; reset -> 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-entry skid pipeline stage register with flush/exception clear (optional PIPE_STALL_CNT_EN stall counter)
module pipe_stage_reg #(
    parameter int          DATA_W = 128,
    parameter logic [31:0] EXC_PC = 32'h0000_4180
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic              in_bd,
    input  logic [4:0]        in_exc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic              out_bd,
    output logic [4:0]        out_exc,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // The out_* registers are the main entry; the skid entry only catches
    // the one beat that arrives while the downstream is stalled.
    logic [31:0]       skid_pc;
    logic              skid_bd;
    logic [4:0]        skid_exc;
    logic [DATA_W-1:0] skid_data;

    logic accept;
    logic drain;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    // Next-state and load-enable decode from the handshake.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        accept         = in_valid & in_ready;
        drain          = out_valid & out_ready;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d      = FULL;
                    load_main_in = 1'b1;
                end
            end
            FULL: begin
                if (accept && drain) begin
                    load_main_in = 1'b1;
                end else if (drain) begin
                    state_d = EMPTY;
                end else if (accept) begin
                    state_d   = SKID;
                    load_skid = 1'b1;
                end
            end
            SKID: begin
                if (drain) begin
                    state_d        = FULL;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State and handshake flags; in_ready/out_valid are registered from the
    // next state so in_ready has no combinational path from out_ready.
    always_ff @(posedge clk) begin
        if (reset || req || flush) begin
            state_q   <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d != SKID);
            out_valid <= (state_d != EMPTY);
        end
    end

    // Main entry: cleared by reset/flush, loaded with the handler PC on req,
    // otherwise refilled from the input or from the skid entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_pc   <= '0;
            out_bd   <= 1'b0;
            out_exc  <= '0;
            out_data <= '0;
        end else if (req || flush) begin
            out_pc   <= req ? EXC_PC : 32'h0;
            out_bd   <= 1'b0;
            out_exc  <= '0;
            out_data <= '0;
        end else if (load_main_in) begin
            out_pc   <= in_pc;
            out_bd   <= in_bd;
            out_exc  <= in_exc;
            out_data <= in_data;
        end else if (load_main_skid) begin
            out_pc   <= skid_pc;
            out_bd   <= skid_bd;
            out_exc  <= skid_exc;
            out_data <= skid_data;
        end
    end

    // Skid entry: captures the input when main is stalled and occupied.
    always_ff @(posedge clk) begin
        if (reset || req || flush) begin
            skid_pc   <= '0;
            skid_bd   <= 1'b0;
            skid_exc  <= '0;
            skid_data <= '0;
        end else if (load_skid) begin
            skid_pc   <= in_pc;
            skid_bd   <= in_bd;
            skid_exc  <= in_exc;
            skid_data <= in_data;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    // Saturating count of cycles the downstream held off a valid entry;
    // only reset clears it so flushes do not hide stall history.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized self-checking bench for pipe_stage_reg against a queue model
module tb_pipe_stage_reg;

    localparam int          DATA_W = 128;
    localparam logic [31:0] EXC_PC = 32'h0000_4180;

    logic              clk = 1'b0;
    logic              reset, flush, req, in_valid, in_ready, in_bd, out_valid, out_ready, out_bd;
    logic [31:0]       in_pc, out_pc;
    logic [4:0]        in_exc, out_exc;
    logic [DATA_W-1:0] in_data, out_data;
`ifdef PIPE_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DATA_W), .EXC_PC(EXC_PC)) dut (
        .clk(clk), .reset(reset), .flush(flush), .req(req),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_bd(in_bd),
        .in_exc(in_exc), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_bd(out_bd),
        .out_exc(out_exc), .out_data(out_data)
`ifdef PIPE_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    typedef struct {
        logic [31:0]       pc;
        logic              bd;
        logic [4:0]        exc;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t q[$];
    ent_t cur;
    int   m_stall;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ent_t zero_ent(input logic [31:0] pc);
        ent_t e;
        e.pc = pc; e.bd = 1'b0; e.exc = '0; e.data = '0;
        return e;
    endfunction

    // Model: the stage is a FIFO of at most two entries seen through its head.
    task automatic model_edge();
        bit rdy, drn;
        if (reset) begin
            q.delete(); cur = zero_ent(32'h0); m_stall = 0;
        end else begin
            if (q.size() > 0 && !out_ready && m_stall < 16'hFFFF) m_stall++;
            if (req) begin
                q.delete(); cur = zero_ent(EXC_PC);
            end else if (flush) begin
                q.delete(); cur = zero_ent(32'h0);
            end else begin
                rdy = (q.size() < 2);
                drn = (q.size() > 0) && out_ready;
                if (drn) void'(q.pop_front());
                if (in_valid && rdy) begin
                    ent_t e;
                    e.pc = in_pc; e.bd = in_bd; e.exc = in_exc; e.data = in_data;
                    q.push_back(e);
                end
                if (q.size() > 0) cur = q[0];
            end
        end
    endtask

    task automatic compare_all();
        chk("out_valid", DATA_W'(out_valid), DATA_W'(q.size() > 0));
        chk("in_ready",  DATA_W'(in_ready),  DATA_W'(q.size() < 2));
        chk("out_pc",    DATA_W'(out_pc),    DATA_W'(cur.pc));
        chk("out_bd",    DATA_W'(out_bd),    DATA_W'(cur.bd));
        chk("out_exc",   DATA_W'(out_exc),   DATA_W'(cur.exc));
        chk("out_data",  out_data,           cur.data);
`ifdef PIPE_STALL_CNT_EN
        chk("stall_cnt", DATA_W'(stall_cnt), DATA_W'(m_stall));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle();
        reset = 0; flush = 0; req = 0; in_valid = 0; in_bd = 0; in_exc = 0; in_data = '0;
    endtask

    task automatic push(input logic [31:0] pc, input logic bd);
        in_valid = 1; in_pc = pc; in_bd = bd; in_exc = 5'h3; in_data = {4{pc}};
    endtask

    initial begin
        idle(); in_pc = 0; out_ready = 1; reset = 1;
        q.delete(); cur = zero_ent(32'h0); m_stall = 0;
        step(); step();
        reset = 0;
        chk("rst_out_valid", DATA_W'(out_valid), '0);
        chk("rst_in_ready",  DATA_W'(in_ready),  DATA_W'(1));
        chk("rst_out_pc",    DATA_W'(out_pc),    '0);

        push(32'h3000, 1'b1); out_ready = 1;
        step();
        chk("lat_valid", DATA_W'(out_valid), DATA_W'(1));
        chk("lat_pc",    DATA_W'(out_pc),    DATA_W'(32'h3000));
        chk("lat_bd",    DATA_W'(out_bd),    DATA_W'(1));

        out_ready = 0; push(32'h3004, 1'b0);
        step();
        chk("skid_in_ready", DATA_W'(in_ready), '0);
        chk("skid_head_pc",  DATA_W'(out_pc),   DATA_W'(32'h3000));
        chk("skid_bd_new",   DATA_W'(out_bd),   DATA_W'(1));
        in_valid = 0; out_ready = 1;
        step();
        chk("skid_second_pc", DATA_W'(out_pc), DATA_W'(32'h3004));
        chk("skid_second_bd", DATA_W'(out_bd), '0);
        step();
        chk("drained_valid", DATA_W'(out_valid), '0);

        out_ready = 0; push(32'h3010, 1'b0); step();
        push(32'h3014, 1'b1); step();
        in_valid = 0; req = 1; step(); req = 0;
        chk("req_valid",    DATA_W'(out_valid), '0);
        chk("req_pc",       DATA_W'(out_pc),    DATA_W'(EXC_PC));
        chk("req_exc",      DATA_W'(out_exc),   '0);
        chk("req_in_ready", DATA_W'(in_ready),  DATA_W'(1));

        push(32'h3000, 1'b0); step();
        push(32'h3008, 1'b1); flush = 1; step(); flush = 0; in_valid = 0;
        chk("flush_valid", DATA_W'(out_valid), '0);
        chk("flush_pc",    DATA_W'(out_pc),    '0);
        out_ready = 1; step();
        chk("flush_gone", DATA_W'(out_valid), '0);

        flush = 1; req = 1; step();
        chk("req_over_flush", DATA_W'(out_pc), DATA_W'(EXC_PC));
        flush = 0; reset = 1; step();
        chk("reset_over_req", DATA_W'(out_pc), '0);
        idle();

`ifdef PIPE_STALL_CNT_EN
        out_ready = 0; push(32'h3020, 1'b0); step(); in_valid = 0;
        for (int i = 0; i < 70000; i++) step();
        chk("stall_sat", DATA_W'(stall_cnt), DATA_W'(16'hFFFF));
        flush = 1; step(); flush = 0;
        chk("stall_flush", DATA_W'(stall_cnt), DATA_W'(16'hFFFF));
        reset = 1; step(); reset = 0;
        chk("stall_reset", DATA_W'(stall_cnt), '0);
`endif

        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            req       = ($urandom_range(0, 79) == 0);
            flush     = ($urandom_range(0, 49) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (i % 500 < 250) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            in_pc     = $urandom;
            in_bd     = 1'($urandom);
            in_exc    = 5'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
